delayprog_edge: RTL
===================

Name: delayprog_edge

Overview:
- Parametrised, clocked successor to the fixed 1 ns delay cell.
- Provides N independent channels. Each channel delays selected input edges by a programmable number of clock cycles.
- Pulses shorter than the programmed delay are suppressed (deglitch). Edges not selected for delay pass with one cycle of latency.
- Sits in stepdown core-state logic wherever a fixed delay cell was previously instanced and a tunable delay is needed.

Parameters:
- N, 1, number of channels.
- DW, 4, width of the delay-count field; maximum delay is 2^DW-1 cycles.
- EDGE, 2, edge(s) to delay: 0 = rising only, 1 = falling only, 2 = both.
- OINIT, 0, reset value of each channel's input sample and output (per-bit, N bits wide).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- CELV  input  1  supply pin; no logic function; keep it on the port list.
- CELG  input  1  ground pin; no logic function.
- CELSUB  input  1  substrate pin; no logic function.
- en  input  1  1 = delay active; 0 = bypass (o follows input with 1-cycle latency).
- dly  input  DW  delay in cycles, shared by all channels, latched per channel at count start.
- i  input  N  channel inputs.
- o  output  N  delayed channel outputs (registered).
- busy  output  N  1 while the channel is counting toward a pending edge.
- gl  output  N  one-cycle pulse when a pending edge is aborted (glitch suppressed).

Behaviour:

Reset (rst=1 at a clk edge), per channel:
- s (input sample) <= OINIT; o <= OINIT.
- cnt <= 0; dly_l <= 0; state <= IDLE.
- busy=0, gl=0.
- Reset mid-count discards any pending edge, with no gl pulse.

Every cycle, per channel:
- s <= i[k]. This 1-cycle sample stage is the only input path; i is assumed synchronous to clk.

Edge classification:
- Pending direction is rising when s=1 and o=0, falling when s=0 and o=1.
- The edge is "delayed" if EDGE allows that direction; otherwise it is "direct".

State IDLE (busy=0):
- s==o: hold.
- en=0, or direct edge: o <= s (output changes 1 cycle after s, 2 clk edges after i).
- Delayed edge with dly==0: o <= s immediately; stay IDLE (same latency as a direct edge).
- Delayed edge with dly>0: dly_l <= dly, cnt <= 1, go to COUNT.

State COUNT (busy=1):
- s==o (input returned before expiry): abort. cnt <= 0, go to IDLE, gl=1 for exactly one cycle, o unchanged.
- en goes 0: o <= s, cnt <= 0, go to IDLE, no gl pulse.
- cnt==dly_l: o <= s, cnt <= 0, go to IDLE.
- Otherwise: cnt <= cnt+1.

Counter and dly handling:
- cnt is DW bits and never wraps, because cnt ≤ dly_l ≤ 2^DW-1.
- Changes on dly during COUNT do not affect the running count; the new value applies at the next count start.

Latency:
- Delayed edge on i at cycle t reaches o at t+1+dly (cycles measured as clk edges from the edge where i is first sampled).
- An input level must stay stable for dly+1 consecutive samples to propagate.

Channel behaviour:
- Channels are fully independent.
- Simultaneous edges on several channels are each handled per the rules above.

Outputs:
- gl is registered and asserted in the cycle after the abort decision.
- busy is combinational from state.

Test Plan:
1. rst=1, 3 cycles, with OINIT=0 and i=1 → o=0, busy=0, gl=0 throughout. Release rst → o rises 2 cycles later (rst held i sampling at OINIT).
2. EDGE=2, dly=5, en=1: i 0→1, held 20 cycles → o rises exactly 6 cycles after i is sampled high; busy high for 5 cycles. Then i 1→0 → o falls 6 cycles later.
3. EDGE=0, dly=5: rising edge delayed 6 cycles; falling edge passes with 1-cycle latency from s, busy never asserted on fall.
4. dly=5: 3-cycle high pulse on i → o stays 0; gl pulses once 1 cycle after the pulse end reaches s. A 6-cycle pulse → o pulses high for 6 cycles.
5. dly=8, change dly to 2 at count=3 → o still changes at count=8. dly=0 → behaves as a direct edge. dly=15 (DW=4) → count reaches 15 with no wrap.
6. N=4: staggered edges on channels 0–3, en dropped to 0 mid-count on channel 2 → channel 2 o follows s next cycle with no gl pulse; other channels are unaffected. rst mid-count → all o=OINIT, busy=0.

Source files
------------

// File: rtl/delayprog_edge.sv
// Programmable per-channel edge delay with deglitch: selected edges are held back dly cycles,
// pulses shorter than the delay are dropped (gl flags the drop), other edges pass in one cycle.
module delayprog_edge #(
  parameter int unsigned    N     = 1,
  parameter int unsigned    DW    = 4,
  parameter int unsigned    EDGE  = 2,
  parameter logic [N-1:0]   OINIT = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CELV,
  input  logic          CELG,
  input  logic          CELSUB,
  input  logic          en,
  input  logic [DW-1:0] dly,
  input  logic [N-1:0]  i,
  output logic [N-1:0]  o,
  output logic [N-1:0]  busy,
  output logic [N-1:0]  gl
);

  typedef enum logic {StIdle, StCount} state_e;

  localparam bit DlyRise = (EDGE == 0) || (EDGE == 2);
  localparam bit DlyFall = (EDGE == 1) || (EDGE == 2);

  // Power/ground/substrate pins are carried for netlist compatibility only.
  logic w_unused_pins;
  assign w_unused_pins = ^{CELV, CELG, CELSUB};

  for (genvar k = 0; k < N; k++) begin : g_ch
    state_e        r_state, w_state_d;
    logic          r_s, r_o, w_o_d;
    logic          r_gl, w_gl_d;
    logic [DW-1:0] r_cnt, w_cnt_d;
    logic [DW-1:0] r_dly_l, w_dly_l_d;
    logic          w_pend, w_rise, w_delayed, w_start;

    assign w_pend    = r_s ^ r_o;
    assign w_rise    = r_s & ~r_o;
    assign w_delayed = w_rise ? DlyRise : DlyFall;
    // A zero delay behaves exactly like a direct edge, so it never enters the count state.
    assign w_start   = w_pend && en && w_delayed && (dly != '0);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= StIdle;
        r_s     <= OINIT[k];
        r_o     <= OINIT[k];
        r_gl    <= 1'b0;
        r_cnt   <= '0;
        r_dly_l <= '0;
      end else begin
        r_state <= w_state_d;
        r_s     <= i[k];
        r_o     <= w_o_d;
        r_gl    <= w_gl_d;
        r_cnt   <= w_cnt_d;
        r_dly_l <= w_dly_l_d;
      end
    end

    always_comb begin
      w_state_d = r_state;
      case (r_state)
        StIdle: begin
          if (w_start) begin
            w_state_d = StCount;
          end
        end
        StCount: begin
          if (!w_pend || !en || (r_cnt == r_dly_l)) begin
            w_state_d = StIdle;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end

    always_comb begin
      w_o_d     = r_o;
      w_gl_d    = 1'b0;
      w_cnt_d   = r_cnt;
      w_dly_l_d = r_dly_l;
      case (r_state)
        StIdle: begin
          if (w_start) begin
            w_dly_l_d = dly;
            w_cnt_d   = DW'(1);
          end else if (w_pend) begin
            w_o_d = r_s;
          end
        end
        StCount: begin
          if (!w_pend) begin
            // Input returned to the output level before expiry: drop the pulse.
            w_cnt_d = '0;
            w_gl_d  = 1'b1;
          end else if (!en || (r_cnt == r_dly_l)) begin
            w_o_d   = r_s;
            w_cnt_d = '0;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        default: begin
          w_cnt_d = '0;
        end
      endcase
    end

    assign o[k]    = r_o;
    assign busy[k] = (r_state == StCount);
    assign gl[k]   = r_gl;
  end

endmodule
